pipeline_ctrl: RTL

//  Central sequencer for the 5-stage pipeline latches (fetch, decode, execute, memory).

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/pipeline_ctrl_hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: register index type and sequencer states.
package pipeline_ctrl_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in execute whose destination feeds a decode-stage source.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_wsel,
  input  regbits_t dec_rsel1,
  input  regbits_t dec_rsel2,
  output logic     luse
);

  // Register zero is hardwired, so a load targeting it can never create a dependency.
  assign luse = ex_dREN && (ex_wsel != '0) &&
                ((ex_wsel == dec_rsel1) || (ex_wsel == dec_rsel2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch sequencer: resolves dmem waits, load-use, redirects, icache misses, halt/drain.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
`ifdef PIPE_CTRL_PERF_EN
#(
  parameter int PERF_W = 32
)
`endif
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_dREN,
  input  logic              mem_dWEN,
  input  logic              mem_pcsrc,
  input  logic              mem_halt,
  input  logic              ex_dREN,
  input  regbits_t          ex_wsel,
  input  regbits_t          dec_rsel1,
  input  regbits_t          dec_rsel2,
  output logic              pc_en,
  output logic              fl_en,
  output logic              fl_flush,
  output logic              dl_en,
  output logic              dl_flush,
  output logic              el_en,
  output logic              el_flush,
  output logic              ml_en,
  output logic              ml_flush,
  output logic              halt
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  pipe_state_t state_reg, state_next;

  logic luse;
  logic dstall;
  logic active;
  logic rule_dstall, rule_halt, rule_redir, rule_luse, rule_imiss;

  hazard_detect u_hazard_detect (
    .ex_dREN   (ex_dREN),
    .ex_wsel   (ex_wsel),
    .dec_rsel1 (dec_rsel1),
    .dec_rsel2 (dec_rsel2),
    .luse      (luse)
  );

  // A dhit with no outstanding request is ignored because dstall is only raised by dreq.
  assign dstall = (mem_dREN | mem_dWEN) & ~dhit;
  assign active = (state_reg == RUN) || (state_reg == DWAIT);

  assign rule_dstall = active & dstall;
  assign rule_halt   = active & ~dstall & mem_halt;
  assign rule_redir  = active & ~dstall & ~mem_halt & mem_pcsrc;
  assign rule_luse   = active & ~dstall & ~mem_halt & ~mem_pcsrc & luse;
  assign rule_imiss  = active & ~dstall & ~mem_halt & ~mem_pcsrc & ~luse & ~ihit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN, DWAIT: begin
        if (dstall)        state_next = DWAIT;
        else if (mem_halt) state_next = DRAIN;
        else               state_next = RUN;
      end
      DRAIN:   state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_en    = 1'b0;
    fl_en    = 1'b0;
    fl_flush = 1'b0;
    dl_en    = 1'b0;
    dl_flush = 1'b0;
    el_en    = 1'b0;
    el_flush = 1'b0;
    ml_en    = 1'b0;
    ml_flush = 1'b0;
    case (state_reg)
      RUN, DWAIT: begin
        if (rule_dstall) begin
          // Whole pipe frozen until the data access completes.
        end else if (rule_halt) begin
          fl_flush = 1'b1;
          dl_flush = 1'b1;
          el_flush = 1'b1;
          ml_en    = 1'b1;
        end else if (rule_redir) begin
          pc_en    = 1'b1;
          fl_flush = 1'b1;
          dl_flush = 1'b1;
          el_flush = 1'b1;
          ml_en    = 1'b1;
        end else if (rule_luse) begin
          dl_flush = 1'b1;
          el_en    = 1'b1;
          ml_en    = 1'b1;
        end else if (rule_imiss) begin
          fl_flush = 1'b1;
          dl_en    = 1'b1;
          el_en    = 1'b1;
          ml_en    = 1'b1;
        end else begin
          pc_en = 1'b1;
          fl_en = 1'b1;
          dl_en = 1'b1;
          el_en = 1'b1;
          ml_en = 1'b1;
        end
      end
      DRAIN:   ml_en = 1'b1;
      default: ;
    endcase
  end

  assign halt = (state_reg == HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_reg, flush_cnt_reg;

  // Rules only fire in RUN/DWAIT, so counters stop on their own once draining or halted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((rule_dstall | rule_luse | rule_imiss) && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (rule_redir && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule
